// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the divided-clock period meter.
package clk_meas_pkg;

    // Measurement FSM: waiting for a first edge, inside the high phase, inside the low phase
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meas_state_t;

    localparam int unsigned CNT_W_DEF = 16;

    // Counter value at which a missing edge is declared a stall (all-ones of the default width)
    localparam logic [CNT_W_DEF-1:0] STALL_LIMIT = '1;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one registered copy of its output for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge pulses decoded from the last synchronizer stage and its delayed copy
    always_comb begin
        rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a divided clock in mclk cycles; valid/ready result port.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             stalled,
    output logic             overrun
);

    // Saturation value of the counters; the package constant applies at the default width
    localparam logic [CNT_W-1:0] CNT_MAX =
        (CNT_W == CNT_W_DEF) ? CNT_W'(STALL_LIMIT) : {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [CNT_W-1:0] period_d, high_d;
    logic             valid_d, stalled_d, overrun_d;
    logic             publish_c;
    logic             rise_c, fall_c;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (mclk),
        .rst_n  (rst_n),
        .d      (clk_in),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // State, counters and result/handshake registers
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_cnt_q  <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            stalled     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cnt_q  <= high_cnt_d;
            meas_period <= period_d;
            meas_high   <= high_d;
            meas_valid  <= valid_d;
            stalled     <= stalled_d;
            overrun     <= overrun_d;
        end
    end

    // Next-state: phase tracking, saturating count, stall detection and result publishing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cnt_d = high_cnt_q;
        stalled_d  = stalled;
        period_d   = meas_period;
        high_d     = meas_high;
        valid_d    = meas_valid;
        overrun_d  = overrun;
        publish_c  = 1'b0;
        cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d   = HIGH;
                    cnt_d     = CNT_ONE;
                    stalled_d = 1'b0;
                end
            end
            HIGH: begin
                if (fall_c) begin
                    high_cnt_d = cnt_q;
                    cnt_d      = cnt_inc_c;
                    state_d    = LOW;
                end else if (cnt_q == CNT_MAX) begin
                    stalled_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            LOW: begin
                if (rise_c) begin
                    publish_c = 1'b1;
                    cnt_d     = CNT_ONE;
                    state_d   = HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    stalled_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A transfer retires the current result and clears the drop flag
        if (meas_valid && meas_ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // A new result loads if the slot is free or being emptied this cycle, else it is dropped
        if (publish_c) begin
            if (!meas_valid || meas_ready) begin
                period_d = cnt_q;
                high_d   = high_cnt_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: vector table plus multi-cycle corner sequences.
module tb_clk_period_meter;
    import clk_meas_pkg::*;

    localparam int unsigned W = 8;

    logic         mclk;
    logic         rst_n;
    logic         clk_in;
    logic [W-1:0] meas_period;
    logic [W-1:0] meas_high;
    logic         meas_valid;
    logic         meas_ready;
    logic         stalled;
    logic         overrun;

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
    } res_t;

    typedef struct {
        int hi;
        int lo;
        int nper;
        int exp_period;
        int exp_high;
    } vec_t;

    res_t res_q[$];
    logic valid_seen;
    int   n_checks;
    int   n_err;

    clk_period_meter #(
        .CNT_W       (W),
        .SYNC_STAGES (2)
    ) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .clk_in      (clk_in),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .stalled     (stalled),
        .overrun     (overrun)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // Record every handshake transfer and any appearance of meas_valid
    always @(negedge mclk) begin
        if (meas_valid) valid_seen = 1'b1;
        if (meas_valid && meas_ready) res_q.push_back({meas_period, meas_high});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_clk(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            clk_in = 1'b1;
            steps(hi);
            clk_in = 1'b0;
            steps(lo);
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        clk_in     = 1'b0;
        meas_ready = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
        res_q.delete();
        valid_seen = 1'b0;
    endtask

    task automatic chk_results(input string tag, input int exp_n, input int exp_p, input int exp_h);
        chk({tag, "_count"}, res_q.size(), exp_n);
        for (int i = 0; i < res_q.size(); i++) begin
            chk($sformatf("%s_period[%0d]", tag, i), int'(res_q[i].period), exp_p);
            chk($sformatf("%s_high[%0d]", tag, i), int'(res_q[i].high), exp_h);
        end
    endtask

    vec_t vecs[5];
    int   cyc;

    initial begin
        n_checks   = 0;
        n_err      = 0;
        valid_seen = 1'b0;
        rst_n      = 1'b0;
        clk_in     = 1'b0;
        meas_ready = 1'b0;

        vecs[0] = '{hi: 5, lo: 5, nper: 4, exp_period: 10, exp_high: 5};
        vecs[1] = '{hi: 3, lo: 7, nper: 4, exp_period: 10, exp_high: 3};
        vecs[2] = '{hi: 1, lo: 1, nper: 5, exp_period: 2,  exp_high: 1};
        vecs[3] = '{hi: 2, lo: 5, nper: 3, exp_period: 7,  exp_high: 2};
        vecs[4] = '{hi: 1, lo: 3, nper: 3, exp_period: 4,  exp_high: 1};

        // Reset values
        apply_reset();
        chk("rst_period",  int'(meas_period), 0);
        chk("rst_high",    int'(meas_high), 0);
        chk("rst_valid",   int'(meas_valid), 0);
        chk("rst_stalled", int'(stalled), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Steady waveforms with ready held high: first rise opens, each later rise reports
        foreach (vecs[v]) begin
            apply_reset();
            meas_ready = 1'b1;
            run_clk(vecs[v].hi, vecs[v].lo, vecs[v].nper);
            steps(6);
            chk_results($sformatf("vec%0d", v), vecs[v].nper - 1,
                        vecs[v].exp_period, vecs[v].exp_high);
            chk($sformatf("vec%0d_overrun", v), int'(overrun), 0);
        end

        // First rise after reset produces no result
        apply_reset();
        meas_ready = 1'b1;
        run_clk(3, 7, 1);
        steps(2);
        chk("first_rise_no_valid", int'(valid_seen), 0);

        // Back-pressure: first result held, later ones dropped
        apply_reset();
        run_clk(5, 5, 1);
        run_clk(2, 4, 1);
        run_clk(3, 3, 1);
        clk_in = 1'b1;
        steps(5);
        chk("bp_valid",   int'(meas_valid), 1);
        chk("bp_period",  int'(meas_period), 10);
        chk("bp_high",    int'(meas_high), 5);
        chk("bp_overrun", int'(overrun), 1);
        meas_ready = 1'b1;
        step();
        meas_ready = 1'b0;
        chk("bp_valid_after_xfer",   int'(meas_valid), 0);
        chk("bp_overrun_after_xfer", int'(overrun), 0);
        chk_results("bp_xfer", 1, 10, 5);

        // Stall: clock stops low after three periods
        apply_reset();
        meas_ready = 1'b1;
        run_clk(5, 5, 3);
        chk_results("pre_stall", 2, 10, 5);
        valid_seen = 1'b0;
        cyc = 0;
        while (!stalled && cyc < 400) begin
            step();
            cyc++;
        end
        chk("stall_seen", int'(stalled), 1);
        n_checks++;
        if (cyc < 245 || cyc > 256) begin
            n_err++;
            $display("FAIL stall_latency: got %0d cycles after last edge expected 245..256", cyc);
        end
        chk("stall_fsm_idle", int'(dut.state_q), int'(IDLE));
        chk("stall_no_valid", int'(valid_seen), 0);

        // Restart after stall: flag drops at first detected rise, next full period reported
        res_q.delete();
        clk_in = 1'b1;
        steps(2);
        chk("restart_stalled_before_rise", int'(stalled), 1);
        step();
        chk("restart_stalled_cleared", int'(stalled), 0);
        steps(2);
        clk_in = 1'b0;
        steps(5);
        chk("restart_first_no_valid", int'(valid_seen), 0);
        run_clk(5, 5, 1);
        steps(4);
        chk_results("restart", 1, 10, 5);

        // Reset pulse while the FSM is still in HIGH with a result pending
        apply_reset();
        run_clk(5, 5, 2);
        clk_in = 1'b1;
        steps(5);
        chk("mid_rst_pre_valid", int'(meas_valid), 1);
        clk_in = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_period",  int'(meas_period), 0);
        chk("mid_rst_high",    int'(meas_high), 0);
        chk("mid_rst_valid",   int'(meas_valid), 0);
        chk("mid_rst_stalled", int'(stalled), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        res_q.delete();
        meas_ready = 1'b1;
        steps(3);
        run_clk(3, 7, 2);
        steps(6);
        chk_results("mid_rst_after", 1, 10, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures a divided clock, such as the output of the team's clock divider, in units of `mclk` cycles. It reports the period and high time of each full cycle of that clock through a valid/ready result port. It sits on the consuming side of the divided-clock path and is used for bring-up and self-check of divider settings on the board. It also flags a stalled (missing) input clock and dropped results.

## Interface
Parameters:
- `CNT_W`, default 16: width of the period and high-time counters and results.
- `SYNC_STAGES`, default 2: synchronizer depth on `clk_in`, minimum 2.

Ports:
- `mclk`  in  1: system clock; all logic rises on `mclk`.
- `rst_n`  in  1: reset; one clock, reset is synchronous and active-low.
- `clk_in`  in  1: divided clock under measurement, asynchronous to `mclk` logic.
- `meas_period`  out  `CNT_W`: `mclk` cycles between consecutive detected rising edges.
- `meas_high`  out  `CNT_W`: `mclk` cycles from a detected rising edge to the next detected falling edge.
- `meas_valid`  out  1: result registers hold an unconsumed measurement.
- `meas_ready`  in  1: consumer accepts the result.
- `stalled`  out  1: no edge within 2^`CNT_W`−1 cycles; level signal.
- `overrun`  out  1: sticky flag; a new result was dropped while `meas_valid` was high.

## Operation
- `clk_in` passes through a `SYNC_STAGES`-flop synchronizer, then one registered copy for edge detection. `rise` = sync & ~prev; `fall` = ~sync & prev.
- FSM states: IDLE, HIGH, LOW.
  - IDLE → HIGH on `rise`. Clear `cnt` to 1 and clear `stalled`.
  - HIGH: `cnt`++ each cycle. On `fall`, latch `high_cnt` = `cnt` and go to LOW.
  - LOW: `cnt`++ each cycle. On `rise`, the period equals `cnt`. Publish {period=`cnt`, high=`high_cnt`}, restart `cnt` at 1, go to HIGH.
  - HIGH or LOW: if `cnt` reaches all-ones with no qualifying edge, set `stalled`=1 and go to IDLE. No result is published.
- Publishing rule:
  - If `meas_valid`=0, or `meas_valid`=1 with `meas_ready`=1 in the same cycle, load the result registers and set `meas_valid`=1.
  - Otherwise, drop the new result, keep the old one, and set `overrun`=1.
- Handshake: a transfer occurs when `meas_valid` & `meas_ready` are both high on a rising `mclk` edge.
  - `meas_valid` falls the next cycle unless a new result loads in the same cycle.
  - Result registers are stable while `meas_valid`=1 and not accepted.
- `overrun` clears only on a transfer cycle. A drop in the same cycle takes priority, so `overrun` stays 1.
- The first partial cycle after reset or a stall is never reported. Measurement starts at the first `rise` seen in IDLE.
- Counter arithmetic is unsigned, `CNT_W` bits, and never wraps. Saturation triggers the stall path.

## Timing
- Reset values: `meas_period`=0, `meas_high`=0, `meas_valid`=0, `stalled`=0, `overrun`=0. FSM=IDLE, `cnt`=0, synchronizer flops=0.
- Reset mid-measurement discards all state; there is no partial result.
- Latency from a `clk_in` rising transition to internal `rise`: `SYNC_STAGES`+1 `mclk` cycles. Edge jitter is ±1 cycle.
- `meas_valid` asserts on the cycle after the closing `rise` is detected.
- Minimum measurable phase: 1 cycle each for high and low. Minimum reportable period: 2.

## Structure
- Shared package `clk_meas_pkg`:
  - FSM state typedef {IDLE, HIGH, LOW}.
  - Default `CNT_W`.
  - Stall limit constant, all-ones of `CNT_W`.
- Sub-module `sync_edge_det`: synchronizer plus `rise`/`fall` pulses, parameterized by `SYNC_STAGES`. It is reused by later board blocks.
- Top level holds the FSM, counters and the result/handshake register.

## Test plan
- Steady input: `clk_in` toggles every 5 `mclk` cycles and `meas_ready`=1. Expect `meas_period`=10 and `meas_high`=5 on every valid after the first full cycle.
- Asymmetric duty: high 3, low 7. Expect period=10 and high=3. Also check the first `rise` after reset yields no result.
- Back-pressure: hold `meas_ready`=0 across two periods.
  - Expect the first result to stay stable and `overrun`=1.
  - Then raise `meas_ready` for 1 cycle: `meas_valid`=0 the next cycle, and `overrun` clears.
- Stall: stop `clk_in` after 3 periods with `CNT_W`=8.
  - Expect `stalled`=1 about 255 cycles after the last edge, FSM in IDLE and no spurious valid.
  - Restart `clk_in`: `stalled`=0 at the first `rise`, and the next full period is reported.
- Reset mid-measurement: assert `rst_n`=0 for 1 cycle during HIGH.
  - Expect all outputs to be zero next cycle.
  - The next report comes only after a fresh full period.
- Minimum period: `clk_in` toggles every `mclk` cycle. Expect `meas_period`=2 and `meas_high`=1.
